// File: rtl/ecg_spi_frame_tx.sv
// ============================================================================
// Module      : ecg_spi_frame_tx
// Description : Serialises strobed {dc, load} words onto a 4-wire SPI link
//               (mode 0). A one-deep pending buffer absorbs back-to-back
//               strobes. A sticky overrun flag is set when a word is dropped.
//               Optional macro ECG_SPI_LSB_FIRST_EN selects LSB-first order.
//               Without the macro, frames are sent MSB first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ecg_spi_frame_tx #(
  parameter int WORD_W  = 12,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] load,
  input  logic              ds,
  input  logic              dc,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              dc_out,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  logic [1:0]        state;
  logic [CNT_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_pos;     // position in transmit order, 0 = first bit
  logic [WORD_W-1:0] frame;       // word in flight, frozen while cs_n is low
  logic              ds_q;
  logic              pend_valid;
  logic [WORD_W-1:0] pend_word;
  logic              pend_dc;

  logic              strobe;
  logic              div_last;
  logic              frame_end;
  logic              launch;
  logic [WORD_W-1:0] launch_word;
  logic              launch_dc;

  // Bit presented at transmit position pos of word w.
  function automatic logic pick(input logic [WORD_W-1:0] w,
                                input logic [BIT_W-1:0]  pos);
`ifdef ECG_SPI_LSB_FIRST_EN
    return w[pos];
`else
    return w[BIT_LAST - pos];
`endif
  endfunction

  assign strobe    = ds & ~ds_q;
  assign div_last  = (div_cnt == DIV_LAST);
  assign frame_end = (state == ST_GAP) && div_last;
  // A frame starts from IDLE, or straight out of GAP so the link never idles
  // when work is waiting; the pending word always has priority over a new one.
  assign launch      = (strobe || pend_valid) && ((state == ST_IDLE) || frame_end);
  assign launch_word = pend_valid ? pend_word : load;
  assign launch_dc   = pend_valid ? pend_dc   : dc;
  assign done        = frame_end;

  // Frame sequencer: SETUP, 2*WORD_W SCLK phases, then GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      div_cnt <= '0;
      bit_pos <= '0;
      frame   <= '0;
      ds_q    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      dc_out  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ds_q <= ds;
      if (launch) begin
        state   <= ST_SETUP;
        div_cnt <= '0;
        bit_pos <= '0;
        frame   <= launch_word;
        dc_out  <= launch_dc;
        mosi    <= pick(launch_word, '0);
        cs_n    <= 1'b0;
        sclk    <= 1'b0;
        busy    <= 1'b1;
      end else begin
        case (state)
          ST_SETUP: begin
            if (div_last) begin
              state   <= ST_SHIFT;
              div_cnt <= '0;
              sclk    <= 1'b1;
            end else begin
              div_cnt <= div_cnt + CNT_W'(1);
            end
          end
          ST_SHIFT: begin
            if (!div_last) begin
              div_cnt <= div_cnt + CNT_W'(1);
            end else begin
              div_cnt <= '0;
              if (sclk) begin
                // Falling edge: present the next bit for the next rising edge.
                sclk <= 1'b0;
                if (bit_pos != BIT_LAST) begin
                  mosi <= pick(frame, bit_pos + BIT_W'(1));
                end
              end else if (bit_pos == BIT_LAST) begin
                state <= ST_GAP;
                cs_n  <= 1'b1;
                mosi  <= 1'b0;
              end else begin
                sclk    <= 1'b1;
                bit_pos <= bit_pos + BIT_W'(1);
              end
            end
          end
          ST_GAP: begin
            div_cnt <= '0;
            if (div_last) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              div_cnt <= div_cnt + CNT_W'(1);
            end
          end
          default: begin
            div_cnt <= '0;
          end
        endcase
      end
    end
  end

  // Pending slot and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_word  <= '0;
      pend_dc    <= 1'b0;
      overrun    <= 1'b0;
    end else if (launch && pend_valid) begin
      // Pending is consumed; a simultaneous strobe refills it.
      pend_valid <= strobe;
      if (strobe) begin
        pend_word <= load;
        pend_dc   <= dc;
      end
    end else if (strobe && !launch) begin
      if (!pend_valid) begin
        pend_valid <= 1'b1;
        pend_word  <= load;
        pend_dc    <= dc;
      end else begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
